// File: rtl/serial_paralelo_param.sv
// serial_paralelo_param: 1-bit serial to WIDTH-bit parallel deserializer with
// comma-based word alignment, lock qualification and misalignment detection.
// Build option: define SP_MSB_FIRST_EN for MSB-first bit order (default LSB-first).
module serial_paralelo_param #(
  parameter int unsigned       WIDTH        = 8,
  parameter logic [WIDTH-1:0]  COMMA        = WIDTH'(8'hBC),
  parameter int unsigned       COMMA_COUNT  = 4,
  parameter int unsigned       MISALIGN_MAX = 2
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_rx,
  output logic             valid_rx,
  output logic             word_stb,
  output logic             active,
  output logic             sync_lost
);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ALIGN,
    ST_ACTIVE
  } state_t;

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]      CC_TGT   = 4'(COMMA_COUNT);
  localparam logic [3:0]      MM_TGT   = 4'(MISALIGN_MAX);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       comma_cnt_q, comma_cnt_d;
  logic [3:0]       mis_cnt_q, mis_cnt_d;
  logic [WIDTH-1:0] data_rx_q, data_rx_d;
  logic             valid_rx_q, valid_rx_d;
  logic             word_stb_q, word_stb_d;
  logic             active_q, active_d;
  logic             sync_lost_q, sync_lost_d;

  logic [WIDTH-1:0] sr_next;
  logic             is_comma;
  logic             boundary;
  logic [3:0]       comma_inc;
  logic [3:0]       mis_inc;

  // Next-state, counters and output pulses, all judged on the post-shift word
  always_comb begin
`ifdef SP_MSB_FIRST_EN
    sr_next = {sr_q[WIDTH-2:0], data_in};
`else
    sr_next = {data_in, sr_q[WIDTH-1:1]};
`endif
    is_comma  = (sr_next == COMMA);
    boundary  = (state_q != ST_SEARCH) && (bit_cnt_q == LAST_BIT);
    comma_inc = (comma_cnt_q == 4'hF) ? comma_cnt_q : comma_cnt_q + 4'd1;
    mis_inc   = (mis_cnt_q == 4'hF) ? mis_cnt_q : mis_cnt_q + 4'd1;

    state_d     = state_q;
    sr_d        = sr_next;
    comma_cnt_d = comma_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    data_rx_d   = data_rx_q;
    valid_rx_d  = 1'b0;
    word_stb_d  = 1'b0;
    sync_lost_d = 1'b0;

    // bit_cnt holds at its top value while searching instead of wrapping
    if (boundary) begin
      bit_cnt_d = '0;
    end else if (bit_cnt_q == LAST_BIT) begin
      bit_cnt_d = bit_cnt_q;
    end else begin
      bit_cnt_d = bit_cnt_q + CW'(1);
    end

    case (state_q)
      ST_SEARCH: begin
        if (is_comma) begin
          bit_cnt_d   = '0;
          comma_cnt_d = 4'd1;
          if (CC_TGT <= 4'd1) begin
            state_d   = ST_ACTIVE;
            mis_cnt_d = '0;
          end else begin
            state_d = ST_ALIGN;
          end
        end
      end
      ST_ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_inc;
            if (comma_inc >= CC_TGT) begin
              state_d   = ST_ACTIVE;
              mis_cnt_d = '0;
            end
          end else begin
            state_d     = ST_SEARCH;
            comma_cnt_d = '0;
            sync_lost_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary) begin
          data_rx_d  = sr_next;
          word_stb_d = 1'b1;
          valid_rx_d = !is_comma;
          if (is_comma) begin
            mis_cnt_d = '0;
          end
        end else if (is_comma) begin
          mis_cnt_d = mis_inc;
          if (mis_inc >= MM_TGT) begin
            state_d     = ST_SEARCH;
            mis_cnt_d   = '0;
            comma_cnt_d = '0;
            sync_lost_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase

    active_d = (state_d == ST_ACTIVE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      sr_q        <= ~COMMA;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      mis_cnt_q   <= '0;
      data_rx_q   <= '0;
      valid_rx_q  <= 1'b0;
      word_stb_q  <= 1'b0;
      active_q    <= 1'b0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      data_rx_q   <= data_rx_d;
      valid_rx_q  <= valid_rx_d;
      word_stb_q  <= word_stb_d;
      active_q    <= active_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  assign data_rx   = data_rx_q;
  assign valid_rx  = valid_rx_q;
  assign word_stb  = word_stb_q;
  assign active    = active_q;
  assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Bench for serial_paralelo_param: an 8-bit default instance and a 10-bit
// instance (COMMA 10'h17C), both checked every edge against a bit-history
// reference model, plus directed checks for lock, data, loss and reset.
module tb_serial_paralelo_param;

`ifdef SP_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  localparam logic [15:0] C8  = 16'h00BC;
  localparam logic [15:0] C10 = 16'h017C;
  localparam int CC = 4;
  localparam int MM = 2;
  localparam int M_SEARCH = 0;
  localparam int M_ALIGN  = 1;
  localparam int M_ACTIVE = 2;

  logic       clk_32f = 1'b0;
  logic       rst, d8, d10;
  logic [7:0] data8;
  logic [9:0] data10;
  logic       valid8, stb8, active8, lost8;
  logic       valid10, stb10, active10, lost10;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_param dut8 (
    .clk_32f(clk_32f), .reset(rst), .data_in(d8),
    .data_rx(data8), .valid_rx(valid8), .word_stb(stb8),
    .active(active8), .sync_lost(lost8)
  );

  serial_paralelo_param #(.WIDTH(10), .COMMA(10'h17C), .COMMA_COUNT(4), .MISALIGN_MAX(2)) dut10 (
    .clk_32f(clk_32f), .reset(rst), .data_in(d10),
    .data_rx(data10), .valid_rx(valid10), .word_stb(stb10),
    .active(active10), .sync_lost(lost10)
  );

  typedef struct {
    int          mode;
    int          phase;
    int          ccnt;
    int          mcnt;
    logic [15:0] data;
    bit          valid;
    bit          stb;
    bit          act;
    bit          lost;
  } mdl_t;

  mdl_t m8, m10;
  bit   h8[$], h10[$];
  bit   s8[$], s10[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int          e_cnt, rise8, n_valid8, n_stb8, n_lost8, lost_act8, n_valid10;
  logic [15:0] vdata[$];
  int          vedge[$];
  logic [15:0] last_data10;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Last w received bits assembled into a word in the build's bit order
  function automatic logic [15:0] window(input bit h[$], input int w);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < w; i++) begin
      if (MSB_FIRST) v[w-1-i] = h[h.size()-w+i];
      else           v[i]     = h[h.size()-w+i];
    end
    return v;
  endfunction

  task automatic model_edge(input int id, input bit b, input bit r);
    mdl_t        m;
    bit          h[$];
    int          w;
    logic [15:0] c, nc, wd;
    bit          bnd, hit;
    if (id == 0) begin m = m8;  h = h8;  w = 8;  c = C8;  end
    else         begin m = m10; h = h10; w = 10; c = C10; end
    if (r) begin
      m.mode = M_SEARCH; m.phase = 0; m.ccnt = 0; m.mcnt = 0;
      m.data = '0; m.valid = 0; m.stb = 0; m.lost = 0;
      nc = ~c;
      h.delete();
      for (int i = 0; i < w; i++) h.push_back(MSB_FIRST ? nc[w-1-i] : nc[i]);
    end else begin
      h.push_back(b);
      if (h.size() > 32) void'(h.pop_front());
      wd  = window(h, w);
      hit = (wd == c);
      m.valid = 0; m.stb = 0; m.lost = 0;
      if (m.mode == M_SEARCH) begin
        if (hit) begin
          m.phase = 0;
          m.ccnt  = 1;
          if (CC == 1) begin m.mode = M_ACTIVE; m.mcnt = 0; end
          else m.mode = M_ALIGN;
        end
      end else begin
        m.phase++;
        bnd = (m.phase == w);
        if (bnd) m.phase = 0;
        if (m.mode == M_ALIGN) begin
          if (bnd) begin
            if (hit) begin
              m.ccnt++;
              if (m.ccnt >= CC) begin m.mode = M_ACTIVE; m.mcnt = 0; end
            end else begin
              m.mode = M_SEARCH; m.ccnt = 0; m.lost = 1;
            end
          end
        end else begin
          if (bnd) begin
            m.data  = wd;
            m.stb   = 1;
            m.valid = !hit;
            if (hit) m.mcnt = 0;
          end else if (hit) begin
            m.mcnt++;
            if (m.mcnt >= MM) begin m.mode = M_SEARCH; m.mcnt = 0; m.lost = 1; end
          end
        end
      end
    end
    m.act = (m.mode == M_ACTIVE);
    if (id == 0) begin m8 = m; h8 = h; end
    else         begin m10 = m; h10 = h; end
  endtask

  task automatic clr();
    e_cnt = 0; rise8 = 0; n_valid8 = 0; n_stb8 = 0; n_lost8 = 0;
    lost_act8 = -1; n_valid10 = 0; last_data10 = '0;
    vdata.delete(); vedge.delete();
  endtask

  task automatic tick(input bit b8, input bit b10, input bit r);
    rst = r; d8 = b8; d10 = b10;
    @(posedge clk_32f);
    model_edge(0, b8, r);
    model_edge(1, b10, r);
    #1;
    e_cnt++;
    check("data8",   16'(data8),   m8.data);
    check("valid8",  16'(valid8),  16'(m8.valid));
    check("stb8",    16'(stb8),    16'(m8.stb));
    check("active8", 16'(active8), 16'(m8.act));
    check("lost8",   16'(lost8),   16'(m8.lost));
    check("data10",   16'(data10),   m10.data);
    check("valid10",  16'(valid10),  16'(m10.valid));
    check("stb10",    16'(stb10),    16'(m10.stb));
    check("active10", 16'(active10), 16'(m10.act));
    check("lost10",   16'(lost10),   16'(m10.lost));
    if (active8 === 1'b1 && rise8 == 0) rise8 = e_cnt;
    if (valid8 === 1'b1) begin n_valid8++; vdata.push_back(16'(data8)); vedge.push_back(e_cnt); end
    if (stb8 === 1'b1) n_stb8++;
    if (lost8 === 1'b1) begin n_lost8++; lost_act8 = int'(active8); end
    if (valid10 === 1'b1) begin n_valid10++; last_data10 = 16'(data10); end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic send8(input logic [7:0] wd);
    for (int i = 0; i < 8; i++) tick(MSB_FIRST ? wd[7-i] : wd[i], rb(), 1'b0);
  endtask

  task automatic send10(input logic [9:0] wd);
    for (int i = 0; i < 10; i++) tick(rb(), MSB_FIRST ? wd[9-i] : wd[i], 1'b0);
  endtask

  task automatic do_reset();
    tick(rb(), rb(), 1'b1);
  endtask

  task automatic push_word(input int id, input logic [15:0] wd, input int w);
    for (int i = 0; i < w; i++) begin
      bit b;
      b = MSB_FIRST ? wd[w-1-i] : wd[i];
      if (id == 0) s8.push_back(b);
      else         s10.push_back(b);
    end
  endtask

  task automatic build_stream(input int id, input int w, input logic [15:0] c);
    int sz;
    sz = 0;
    while (sz < 3000) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k <= 4)      push_word(id, c, w);
      else if (k <= 8) push_word(id, 16'($urandom), w);
      else begin
        int n;
        n = int'($urandom_range(1, w - 1));
        for (int j = 0; j < n; j++) begin
          if (id == 0) s8.push_back(rb());
          else         s10.push_back(rb());
        end
      end
      sz = (id == 0) ? s8.size() : s10.size();
    end
  endtask

  initial begin
    rst = 1'b1; d8 = 1'b0; d10 = 1'b0;
    do_reset();
    do_reset();
    check("rst_data8",   16'(data8),   16'h0000);
    check("rst_active8", 16'(active8), 16'h0000);
    check("rst_valid8",  16'(valid8),  16'h0000);

    // Four aligned commas from bit phase 0: lock on edge 32, no data valid
    clr();
    repeat (4) send8(8'hBC);
    check("t1_rise_edge", 16'(rise8), 16'd32);
    check("t1_active", 16'(active8), 16'h0001);
    check("t1_valid_cnt", 16'(n_valid8), 16'd0);

    // Random lead-in, lock, two data words and a trailing comma
    do_reset();
    clr();
    repeat (3) tick(rb(), rb(), 1'b0);
    repeat (4) send8(8'hBC);
    send8(8'h5A);
    send8(8'h3C);
    send8(8'hBC);
    check("t2_active", 16'(active8), 16'h0001);
    check("t2_valid_cnt", 16'(n_valid8), 16'd2);
    check("t2_stb_cnt", 16'(n_stb8), 16'd3);
    if (vdata.size() >= 2) begin
      check("t2_word0", vdata[0], 16'h005A);
      check("t2_word1", vdata[1], 16'h003C);
      check("t2_spacing", 16'(vedge[1] - vedge[0]), 16'd8);
    end else begin
      check("t2_word_cnt", 16'(vdata.size()), 16'd2);
    end

    // Bad word while aligning drops back to search
    do_reset();
    clr();
    repeat (2) send8(8'hBC);
    send8(8'h00);
    check("t3_lost_cnt", 16'(n_lost8), 16'd1);
    check("t3_active", 16'(active8), 16'h0000);
    check("t3_rise", 16'(rise8), 16'd0);

    // Three-bit slip in ACTIVE: two misaligned commas lose sync, then re-lock
    do_reset();
    clr();
    repeat (4) send8(8'hBC);
    send8(8'h5A);
    repeat (3) tick(1'b0, rb(), 1'b0);
    repeat (2) send8(8'hBC);
    check("t4_lost_cnt", 16'(n_lost8), 16'd1);
    check("t4_active_at_lost", 16'(lost_act8), 16'd0);
    check("t4_active_off", 16'(active8), 16'h0000);
    repeat (3) send8(8'hBC);
    check("t4_not_yet", 16'(active8), 16'h0000);
    send8(8'hBC);
    check("t4_relock", 16'(active8), 16'h0001);

    // Reset in the middle of a data word
    do_reset();
    clr();
    repeat (4) send8(8'hBC);
    send8(8'h5A);
    for (int i = 0; i < 4; i++) tick(rb(), rb(), 1'b0);
    check("t5_pre_active", 16'(active8), 16'h0001);
    do_reset();
    check("t5_rst_data", 16'(data8), 16'h0000);
    check("t5_rst_active", 16'(active8), 16'h0000);
    check("t5_rst_valid", 16'(valid8), 16'h0000);
    check("t5_rst_stb", 16'(stb8), 16'h0000);
    check("t5_rst_lost", 16'(lost8), 16'h0000);
    repeat (3) send8(8'hBC);
    check("t5_three_commas", 16'(active8), 16'h0000);
    send8(8'hBC);
    check("t5_relock", 16'(active8), 16'h0001);

    // 10-bit instance: four commas then one data word
    do_reset();
    clr();
    repeat (4) send10(10'h17C);
    send10(10'h2A5);
    check("t6_active", 16'(active10), 16'h0001);
    check("t6_valid_cnt", 16'(n_valid10), 16'd1);
    check("t6_data", last_data10, 16'h02A5);

    // Randomised stream of commas, data and slips with sparse resets
    do_reset();
    build_stream(0, 8, C8);
    build_stream(1, 10, C10);
    for (int i = 0; i < 3000; i++) begin
      tick(s8[i], s10[i], ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
